nios2_ocimem_arbiter: RTL and testbench

Arbitrates the Nios II on-chip debug monitor RAM (OCI memory) between two requesters: the JTAG debug-slave action path and the CPU's debug memory slave. It sequences single-port, 1-cycle-latency RAM accesses, holds the JTAG auto-incrementing address pointer and read-data register, and reports ready and error status back to the JTAG shift register. It sits in the system-clock domain, after the JTAG action decode and before the monitor RAM.

---
 rtl/nios2_ocimem_pkg.sv | 30 +++
 rtl/nios2_ocimem_rr_arb.sv | 44 ++++
 rtl/nios2_ocimem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_ocimem_pkg.sv
// Shared types for the OCI monitor RAM arbiter.
// FSM states, width defaults, request and grant encodings.
package nios2_ocimem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_WR,
    ST_CPU_RD,
    ST_CPU_RDD,
    ST_JT_WR,
    ST_JT_RD,
    ST_JT_RDD
  } state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_t;

  localparam int GNT_CPU  = 0;
  localparam int GNT_JTAG = 1;

  localparam logic [1:0] GNT_NONE_M = 2'b00;
  localparam logic [1:0] GNT_CPU_M  = 2'b01;
  localparam logic [1:0] GNT_JTAG_M = 2'b10;

endpackage

// File: rtl/nios2_ocimem_rr_arb.sv
// Two-requester round-robin arbiter, CPU vs JTAG.
// last_jtag only moves on a tie; a lone requester always wins.
module nios2_ocimem_rr_arb
  import nios2_ocimem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cpu_pend,
  input  logic       jtag_pend,
  output logic [1:0] grant
);

  logic last_jtag;
  logic both;

  assign both = cpu_pend & jtag_pend;

  // One-hot grant; on a tie favour whoever lost the last tie.
  always_comb begin
    grant = GNT_NONE_M;
    unique case (1'b1)
      en & both:
        grant = last_jtag ? GNT_CPU_M
                          : GNT_JTAG_M;
      en & jtag_pend & !cpu_pend:
        grant = GNT_JTAG_M;
      en & cpu_pend & !jtag_pend:
        grant = GNT_CPU_M;
      default:
        grant = GNT_NONE_M;
    endcase
  end

  // Remember the winner of the most recent tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_jtag <= 1'b0;
    end else if (en & both) begin
      last_jtag <= grant[GNT_JTAG];
    end
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// OCI monitor RAM sequencer shared by JTAG and CPU.
// Holds the JTAG pointer, data and status registers.
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_set_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_access,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_ready,
  output logic              jtag_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              jt_pend_q;
  req_t              jt_kind_q;
  logic [DATA_W-1:0] jt_wdata_q;
  logic [DATA_W-1:0] jt_rdata_q;
  logic              jt_ready_q;
  logic              jt_err_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic       idle;
  logic       cpu_req;
  logic       jt_busy;
  logic       jt_acc_ok;
  logic       jt_drop;
  logic       jt_req;
  logic       jt_wr_now;
  logic       jt_done;
  logic [1:0] grant;

  assign idle      = state_q == ST_IDLE;
  assign cpu_req   = cpu_read | cpu_write;
  assign jt_busy   = state_q inside
                     {ST_JT_WR, ST_JT_RD, ST_JT_RDD};
  assign jt_acc_ok = jtag_access & !jt_pend_q
                     & !jt_busy;
  assign jt_drop   = jtag_access & !jt_acc_ok;
  assign jt_req    = jt_pend_q | jt_acc_ok;
  assign jt_wr_now = jt_pend_q ? (jt_kind_q == REQ_WR)
                               : jtag_wr;
  assign jt_done   = (state_q == ST_JT_WR)
                   | (state_q == ST_JT_RDD);

  nios2_ocimem_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (idle),
    .cpu_pend  (cpu_req),
    .jtag_pend (jt_req),
    .grant     (grant)
  );

  // Next state and RAM port mux; pointer drives RAM when idle.
  always_comb begin
    state_d         = state_q;
    ram_we          = 1'b0;
    ram_addr        = ptr_q;
    ram_wdata       = jt_wdata_q;
    cpu_waitrequest = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (grant[GNT_JTAG]) begin
          state_d = jt_wr_now ? ST_JT_WR : ST_JT_RD;
        end else if (grant[GNT_CPU]) begin
          state_d = cpu_write ? ST_CPU_WR : ST_CPU_RD;
        end
      end
      ST_CPU_WR: begin
        ram_we          = 1'b1;
        ram_addr        = cpu_address;
        ram_wdata       = cpu_writedata;
        cpu_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      ST_CPU_RD: begin
        ram_addr = cpu_address;
        state_d  = ST_CPU_RDD;
      end
      ST_CPU_RDD: begin
        cpu_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      ST_JT_WR: begin
        ram_we  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_JT_RD: begin
        state_d = ST_JT_RDD;
      end
      ST_JT_RDD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (reset) begin
      ram_we          = 1'b0;
      cpu_waitrequest = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // JTAG request capture, pointer, status and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      jt_pend_q  <= 1'b0;
      jt_kind_q  <= REQ_RD;
      jt_wdata_q <= '0;
      jt_rdata_q <= '0;
      jt_ready_q <= 1'b1;
      jt_err_q   <= 1'b0;
    end else begin
      if (jt_acc_ok) begin
        jt_pend_q  <= 1'b1;
        jt_kind_q  <= jtag_wr ? REQ_WR : REQ_RD;
        jt_wdata_q <= jtag_wdata;
        jt_ready_q <= 1'b0;
      end else if (jt_done) begin
        jt_pend_q  <= 1'b0;
        jt_ready_q <= 1'b1;
      end
      if (jtag_set_addr) begin
        ptr_q <= jtag_addr;
      end else if (jt_done) begin
        ptr_q <= ptr_q + PTR_ONE;
      end
      if (jt_drop) begin
        jt_err_q <= 1'b1;
      end else if (jtag_set_addr) begin
        jt_err_q <= 1'b0;
      end
      if (state_q == ST_JT_RDD) begin
        jt_rdata_q <= ram_rdata;
      end
    end
  end

  // CPU read data register, loaded as the read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
    end else if (state_q == ST_CPU_RDD) begin
      cpu_rdata_q <= ram_rdata;
    end
  end

  assign jtag_rdata   = jt_rdata_q;
  assign jtag_ready   = jt_ready_q;
  assign jtag_error   = jt_err_q;
  assign cpu_readdata = (state_q == ST_CPU_RDD && !reset)
                        ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Bench for nios2_ocimem_arbiter: directed cases
// plus random traffic against a service-slot model.
module tb_nios2_ocimem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          jtag_set_addr = 1'b0;
  logic [AW-1:0] jtag_addr = '0;
  logic          jtag_access = 1'b0;
  logic          jtag_wr = 1'b0;
  logic [DW-1:0] jtag_wdata = '0;
  logic [DW-1:0] jtag_rdata;
  logic          jtag_ready;
  logic          jtag_error;
  logic [AW-1:0] cpu_address = '0;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [DW-1:0] cpu_writedata = '0;
  logic [DW-1:0] cpu_readdata;
  logic          cpu_waitrequest;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .jtag_set_addr   (jtag_set_addr),
    .jtag_addr       (jtag_addr),
    .jtag_access     (jtag_access),
    .jtag_wr         (jtag_wr),
    .jtag_wdata      (jtag_wdata),
    .jtag_rdata      (jtag_rdata),
    .jtag_ready      (jtag_ready),
    .jtag_error      (jtag_error),
    .cpu_address     (cpu_address),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_writedata   (cpu_writedata),
    .cpu_readdata    (cpu_readdata),
    .cpu_waitrequest (cpu_waitrequest),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata)
  );

  // Single-port RAM, one cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [DW-1:0] init_word(int i);
    return 32'hA5A5_0000 ^ (i * 32'h0001_0101);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: memory contents, JTAG registers, service slot.
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] m_ptr;
  bit            m_pend, m_pwr, m_ready, m_err, m_last;
  logic [DW-1:0] m_pwdata, m_jrdata, m_crdata;
  int            srv;
  bit            srv_wr;
  int            srv_ph;
  logic [AW-1:0] srv_addr;
  bit            armed = 1'b0;
  bit            exp_cpu_acc = 1'b0;

  bit            t_last, t_cpu_p, t_j_ok, t_j_p, t_jdone;
  bit            t_wait, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_crd, t_wd;
  int            t_win;

  task automatic chk_regs();
    chk("jtag_ready", jtag_ready, m_ready);
    chk("jtag_error", jtag_error, m_err);
    chk("jtag_rdata", jtag_rdata, m_jrdata);
  endtask

  // Compare process: checks every cycle, then advances model.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (armed) begin
        chk("wait_rst", cpu_waitrequest, 1'b1);
        chk("we_rst", ram_we, 1'b0);
        chk("crd_rst", cpu_readdata, m_crdata);
        chk_regs();
      end
      m_ptr = '0; m_pend = 0; m_pwr = 0;
      m_ready = 1; m_err = 0; m_last = 0;
      m_pwdata = '0; m_jrdata = '0; m_crdata = '0;
      srv = 0; srv_wr = 0; srv_ph = 0;
      srv_addr = '0;
      exp_cpu_acc = 0;
      armed = 1'b1;
    end else if (armed) begin
      t_last = (srv != 0)
             && (srv_ph == (srv_wr ? 0 : 1));
      t_wait = !(srv == 1 && t_last);
      t_we   = (srv != 0) && srv_wr;
      t_addr = (srv == 1 && srv_ph == 0)
               ? srv_addr : m_ptr;
      t_crd  = (srv == 1 && !srv_wr && t_last)
               ? ref_mem[srv_addr] : m_crdata;
      t_wd   = (srv == 1) ? cpu_writedata : m_pwdata;
      chk("cpu_waitrequest", cpu_waitrequest, t_wait);
      chk("ram_we", ram_we, t_we);
      chk("ram_addr", ram_addr, t_addr);
      if (t_we) chk("ram_wdata", ram_wdata, t_wd);
      chk("cpu_readdata", cpu_readdata, t_crd);
      chk_regs();
      exp_cpu_acc = (srv == 1) && t_last;
      t_j_ok  = jtag_access && !m_pend;
      t_jdone = (srv == 2) && t_last;
      if (srv != 0) begin
        if (t_last) begin
          if (srv == 1) begin
            if (srv_wr) ref_mem[srv_addr] = cpu_writedata;
            else m_crdata = ref_mem[srv_addr];
          end else begin
            if (srv_wr) ref_mem[m_ptr] = m_pwdata;
            else m_jrdata = ref_mem[m_ptr];
          end
          srv = 0;
        end else begin
          srv_ph++;
        end
      end else begin
        t_cpu_p = cpu_read || cpu_write;
        t_j_p   = m_pend || t_j_ok;
        t_win   = 0;
        if (t_cpu_p && t_j_p) begin
          t_win  = m_last ? 1 : 2;
          m_last = (t_win == 2);
        end else if (t_j_p) begin
          t_win = 2;
        end else if (t_cpu_p) begin
          t_win = 1;
        end
        if (t_win == 1) begin
          srv = 1; srv_ph = 0;
          srv_wr = cpu_write;
          srv_addr = cpu_address;
        end else if (t_win == 2) begin
          srv = 2; srv_ph = 0;
          srv_wr = m_pend ? m_pwr : jtag_wr;
        end
      end
      if (jtag_access && m_pend) m_err = 1;
      else if (jtag_set_addr) m_err = 0;
      if (t_j_ok) begin
        m_pend = 1; m_pwr = jtag_wr;
        m_pwdata = jtag_wdata; m_ready = 0;
      end
      if (t_jdone) begin
        m_pend = 0; m_ready = 1;
      end
      if (jtag_set_addr) m_ptr = jtag_addr;
      else if (t_jdone) m_ptr = m_ptr + 8'd1;
    end
  end

  task automatic cyc();
    @(negedge clk);
    jtag_access = 1'b0;
    jtag_set_addr = 1'b0;
  endtask

  // Runs n cycles from the current one; records timing.
  task automatic run(input int n, output int cpu_at,
                     output int jt_at, output int lows,
                     output logic [DW-1:0] crd);
    cpu_at = -1; jt_at = -1; lows = 0; crd = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        cyc();
        if (cpu_at >= 0) begin
          cpu_read = 1'b0; cpu_write = 1'b0;
        end
      end
      #3;
      if (!cpu_waitrequest) begin
        lows++;
        if (cpu_at < 0) begin
          cpu_at = i; crd = cpu_readdata;
        end
      end
      if (i > 0 && jtag_ready && jt_at < 0) jt_at = i;
    end
  endtask

  int ca, ja, lw, k;
  logic [DW-1:0] rd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rst_ready", jtag_ready, 1'b1);
    chk("rst_error", jtag_error, 1'b0);
    chk("rst_jrdata", jtag_rdata, 32'h0);
    chk("rst_crdata", cpu_readdata, 32'h0);
    chk("rst_wait", cpu_waitrequest, 1'b1);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_addr", ram_addr, 8'h00);

    // JTAG write at 0xFF, pointer wraps, read back.
    cyc();
    jtag_set_addr = 1; jtag_addr = 8'hFF;
    jtag_access = 1; jtag_wr = 1;
    jtag_wdata = 32'hDEADBEEF;
    cyc(); #3;
    chk("jw_we", ram_we, 1'b1);
    chk("jw_addr", ram_addr, 8'hFF);
    chk("jw_data", ram_wdata, 32'hDEADBEEF);
    chk("jw_busy", jtag_ready, 1'b0);
    cyc(); jtag_access = 1; jtag_wr = 0; #3;
    chk("jw_ready", jtag_ready, 1'b1);
    chk("jw_wrap", ram_addr, 8'h00);
    cyc(); cyc(); cyc(); #3;
    chk("jr_ready", jtag_ready, 1'b1);
    chk("jr_data0", jtag_rdata, 32'hA5A50000);
    chk("jr_ptr", ram_addr, 8'h01);
    cyc();
    jtag_set_addr = 1; jtag_addr = 8'hFF;
    jtag_access = 1; jtag_wr = 0;
    cyc(); cyc(); cyc(); #3;
    chk("jr_dataff", jtag_rdata, 32'hDEADBEEF);

    // CPU write then read at 0x10.
    cyc();
    cpu_write = 1; cpu_address = 8'h10;
    cpu_writedata = 32'h12345678;
    run(8, ca, ja, lw, rd);
    chk("cw_at", ca, 1);
    chk("cw_lows", lw, 1);
    cyc();
    cpu_read = 1; cpu_address = 8'h10;
    run(8, ca, ja, lw, rd);
    chk("cr_at", ca, 2);
    chk("cr_lows", lw, 1);
    chk("cr_data", rd, 32'h12345678);

    // Ties after reset: JTAG first, then CPU first.
    cyc(); reset = 1;
    cyc(); reset = 0;
    cpu_read = 1; cpu_address = 8'h10;
    jtag_access = 1; jtag_wr = 0;
    run(10, ca, ja, lw, rd);
    chk("tie1_jt", ja, 3);
    chk("tie1_cpu", ca, 5);
    chk("tie1_data", rd, 32'h12345678);
    cyc();
    cpu_read = 1; cpu_address = 8'h10;
    jtag_access = 1; jtag_wr = 0;
    run(10, ca, ja, lw, rd);
    chk("tie2_cpu", ca, 2);
    chk("tie2_jt", ja, 6);

    // Overrun behind a CPU read.
    cyc(); jtag_set_addr = 1; jtag_addr = 8'h40;
    cyc(); cpu_read = 1; cpu_address = 8'h20;
    cyc(); jtag_access = 1; jtag_wr = 0;
    cyc(); jtag_access = 1; jtag_wr = 0; #3;
    chk("ovr_err0", jtag_error, 1'b0);
    cyc(); cpu_read = 0; #3;
    chk("ovr_err1", jtag_error, 1'b1);
    cyc(); cyc(); cyc(); #3;
    chk("ovr_ready", jtag_ready, 1'b1);
    chk("ovr_ptr", ram_addr, 8'h41);
    for (int i = 0; i < 3; i++) begin
      cyc(); #3;
      chk("ovr_idle", jtag_ready, 1'b1);
      chk("ovr_ptr2", ram_addr, 8'h41);
    end
    chk("ovr_errhold", jtag_error, 1'b1);
    cyc(); jtag_set_addr = 1; jtag_addr = 8'h41;
    cyc(); #3;
    chk("ovr_clr", jtag_error, 1'b0);

    // Reset during CPU_WR; request held through reset.
    cyc();
    cpu_write = 1; cpu_address = 8'h30;
    cpu_writedata = 32'hCAFEF00D;
    cyc(); reset = 1; #3;
    chk("rwr_we", ram_we, 1'b0);
    chk("rwr_wait", cpu_waitrequest, 1'b1);
    cyc(); reset = 0; #3;
    chk("rwr_ready", jtag_ready, 1'b1);
    chk("rwr_err", jtag_error, 1'b0);
    chk("rwr_jrd", jtag_rdata, 32'h0);
    chk("rwr_crd", cpu_readdata, 32'h0);
    chk("rwr_wait2", cpu_waitrequest, 1'b1);
    chk("rwr_we2", ram_we, 1'b0);
    chk("rwr_addr", ram_addr, 8'h00);
    cyc(); #3;
    chk("rwr_acc", cpu_waitrequest, 1'b0);
    chk("rwr_we3", ram_we, 1'b1);
    chk("rwr_a3", ram_addr, 8'h30);
    chk("rwr_d3", ram_wdata, 32'hCAFEF00D);
    cyc(); cpu_write = 0;

    // Reset during JT_RDD.
    cyc(); jtag_access = 1; jtag_wr = 0;
    cyc();
    cyc(); reset = 1; #3;
    chk("rjt_we", ram_we, 1'b0);
    cyc(); reset = 0; #3;
    chk("rjt_jrd", jtag_rdata, 32'h0);
    chk("rjt_ready", jtag_ready, 1'b1);
    chk("rjt_addr", ram_addr, 8'h00);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (cpu_read || cpu_write) begin
        if (exp_cpu_acc) begin
          cpu_read = 0; cpu_write = 0;
        end
      end else if ($urandom_range(99, 0) < 30) begin
        k = $urandom_range(3, 0);
        cpu_read = (k != 1);
        cpu_write = (k == 1 || k == 2);
        cpu_address = AW'($urandom_range(255, 0));
        cpu_writedata = $urandom;
      end
      if ($urandom_range(99, 0) < 15) begin
        jtag_access = 1;
        jtag_wr = 1'($urandom_range(1, 0));
        jtag_wdata = $urandom;
      end
      if (!m_pend && $urandom_range(99, 0) < 8) begin
        jtag_set_addr = 1;
        jtag_addr = ($urandom_range(99, 0) < 30)
                    ? 8'hFF
                    : AW'($urandom_range(255, 0));
      end
      reset = ($urandom_range(199, 0) == 0);
    end
    cyc(); reset = 0;
    cpu_read = 0; cpu_write = 0;
    repeat (4) cyc();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
